// File: rtl/ad4630_pkg.sv
// Shared constants and encodings for the AD4630 SPI master.
package ad4630_pkg;

  localparam int LANES   = 8;
  localparam int RD_BITS = 6;
  localparam int WR_BITS = 24;
  localparam int HALF_W  = 4;
  localparam int TMR_W   = 4;
  localparam int BIT_W   = 5;

  localparam logic [WR_BITS-1:0] INIT_CFG_IN  = 24'hBF_FF00;
  localparam logic [WR_BITS-1:0] INIT_4LANE   = 24'h00_2080;
  localparam logic [WR_BITS-1:0] INIT_CFG_OUT = 24'h00_1401;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic {
    MODE_RD = 1'b0,
    MODE_WR = 1'b1
  } mode_e;

endpackage

// File: rtl/ad4630_spi_if_sclk_gen.sv
// SCLK generator: counts i_half cycles per level, starting low whenever enabled.
module ad4630_spi_if_sclk_gen
  import ad4630_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [HALF_W-1:0] i_half,
  output logic              o_sclk,
  output logic              o_rise,
  output logic              o_fall
);

  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic              phase_q, phase_d;
  logic [HALF_W-1:0] term;
  logic              at_term;

  assign term    = i_half - HALF_W'(1);
  assign at_term = (cnt_q == term);

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!i_en) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (at_term) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + HALF_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Strobes mark the last cycle of a level, so the level changes on the next edge.
  assign o_sclk = phase_q;
  assign o_rise = i_en & ~phase_q & at_term;
  assign o_fall = i_en &  phase_q & at_term;

endmodule

// File: rtl/ad4630_spi_if.sv
// AD4630 SPI master: 24-bit register writes (mode 1) and 8-lane x 6-bit SDR reads (mode 0).
module ad4630_spi_if
  import ad4630_pkg::*;
#(
  parameter int RD_HALF  = 1,
  parameter int WR_HALF  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rd_start,
  input  logic               i_wr_start,
  input  logic [WR_BITS-1:0] i_wr_data,
  output logic               o_busy,
  output logic               o_spi_done,
  output logic [RD_BITS-1:0] o_adc_data_0,
  output logic [RD_BITS-1:0] o_adc_data_1,
  output logic [RD_BITS-1:0] o_adc_data_2,
  output logic [RD_BITS-1:0] o_adc_data_3,
  output logic [RD_BITS-1:0] o_adc_data_4,
  output logic [RD_BITS-1:0] o_adc_data_5,
  output logic [RD_BITS-1:0] o_adc_data_6,
  output logic [RD_BITS-1:0] o_adc_data_7,
  output logic               o_spi_cs_n,
  output logic               o_spi_sclk,
  output logic               o_spi_sdi,
  input  logic [LANES-1:0]   i_spi_sdo,
  output logic [2:0]         o_dbg_state
);

  state_e                         state_q, state_d;
  mode_e                          mode_q, mode_d;
  logic [TMR_W-1:0]               tmr_q, tmr_d;
  logic [BIT_W-1:0]               bit_q, bit_d;
  logic [WR_BITS-1:0]             tx_q, tx_d;
  logic                           sdi_q, sdi_d;
  logic [LANES-1:0][RD_BITS-1:0]  rx_q, rx_d;
  logic [LANES-1:0][RD_BITS-1:0]  adc_q, adc_d;

  logic              start;
  logic              sclk_en;
  logic              sclk;
  logic              rise;
  logic              fall;
  logic [HALF_W-1:0] half;
  logic [BIT_W-1:0]  last_bit;

  assign start    = i_wr_start | i_rd_start;
  assign sclk_en  = (state_q == ST_SHIFT);
  assign half     = (mode_q == MODE_WR) ? HALF_W'(WR_HALF) : HALF_W'(RD_HALF);
  assign last_bit = (mode_q == MODE_WR) ? BIT_W'(WR_BITS - 1) : BIT_W'(RD_BITS - 1);

  ad4630_spi_if_sclk_gen u_sclk_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (sclk_en),
    .i_half (half),
    .o_sclk (sclk),
    .o_rise (rise),
    .o_fall (fall)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // A simultaneous read request is dropped in favour of the write.
          mode_d  = i_wr_start ? MODE_WR : MODE_RD;
          tmr_d   = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_q == TMR_W'(CS_SETUP - 1)) begin
          tmr_d   = '0;
          bit_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_SHIFT: begin
        if (fall) begin
          if (bit_q == last_bit) begin
            state_d = ST_HOLD;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (tmr_q == TMR_W'(CS_HOLD - 1)) begin
          tmr_d   = '0;
          state_d = ST_DONE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_d  = tx_q;
    sdi_d = sdi_q;
    rx_d  = rx_q;
    adc_d = adc_q;
    if (state_q == ST_IDLE && i_wr_start) tx_d = i_wr_data;
    if (state_q == ST_IDLE && start) rx_d = '0;
    if (state_d != ST_SHIFT) sdi_d = 1'b0;
    // Write data changes as SCLK rises so it is stable at the device's falling-edge sample.
    if (mode_q == MODE_WR && rise) begin
      sdi_d = tx_q[WR_BITS-1];
      tx_d  = {tx_q[WR_BITS-2:0], 1'b0};
    end
    if (mode_q == MODE_RD && fall) begin
      for (int k = 0; k < LANES; k++) begin
        rx_d[k] = {rx_q[k][RD_BITS-2:0], i_spi_sdo[k]};
      end
    end
    if (state_q == ST_HOLD && state_d == ST_DONE && mode_q == MODE_RD) adc_d = rx_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_RD;
      tmr_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      sdi_q   <= 1'b0;
      rx_q    <= '0;
      adc_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      sdi_q   <= sdi_d;
      rx_q    <= rx_d;
      adc_q   <= adc_d;
    end
  end

  assign o_busy       = (state_q != ST_IDLE);
  assign o_spi_done   = (state_q == ST_DONE);
  assign o_spi_cs_n   = ~((state_q == ST_SETUP) | (state_q == ST_SHIFT) | (state_q == ST_HOLD));
  assign o_spi_sclk   = sclk;
  assign o_spi_sdi    = sdi_q;
  assign o_dbg_state  = state_q;
  assign o_adc_data_0 = adc_q[0];
  assign o_adc_data_1 = adc_q[1];
  assign o_adc_data_2 = adc_q[2];
  assign o_adc_data_3 = adc_q[3];
  assign o_adc_data_4 = adc_q[4];
  assign o_adc_data_5 = adc_q[5];
  assign o_adc_data_6 = adc_q[6];
  assign o_adc_data_7 = adc_q[7];

endmodule

// File: tb/tb_ad4630_spi_if.sv
// Bench for ad4630_spi_if: vector table of frames plus reset and back-to-back sequences.
module tb_ad4630_spi_if;
  import ad4630_pkg::*;

  // Handshake: a start pulse is accepted only while o_busy is low; o_spi_done is a
  // one-cycle pulse that retires exactly one accepted frame.

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_rd_start;
  logic        i_wr_start;
  logic [23:0] i_wr_data;
  logic [7:0]  i_spi_sdo;
  logic        o_busy, o_spi_done, o_spi_cs_n, o_spi_sclk, o_spi_sdi;
  logic [5:0]  o_adc_data_0, o_adc_data_1, o_adc_data_2, o_adc_data_3;
  logic [5:0]  o_adc_data_4, o_adc_data_5, o_adc_data_6, o_adc_data_7;
  logic [2:0]  o_dbg_state;
  logic [47:0] adc_all;

  assign adc_all = {o_adc_data_7, o_adc_data_6, o_adc_data_5, o_adc_data_4,
                    o_adc_data_3, o_adc_data_2, o_adc_data_1, o_adc_data_0};

  ad4630_spi_if dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_rd_start   (i_rd_start),
    .i_wr_start   (i_wr_start),
    .i_wr_data    (i_wr_data),
    .o_busy       (o_busy),
    .o_spi_done   (o_spi_done),
    .o_adc_data_0 (o_adc_data_0),
    .o_adc_data_1 (o_adc_data_1),
    .o_adc_data_2 (o_adc_data_2),
    .o_adc_data_3 (o_adc_data_3),
    .o_adc_data_4 (o_adc_data_4),
    .o_adc_data_5 (o_adc_data_5),
    .o_adc_data_6 (o_adc_data_6),
    .o_adc_data_7 (o_adc_data_7),
    .o_spi_cs_n   (o_spi_cs_n),
    .o_spi_sclk   (o_spi_sclk),
    .o_spi_sdi    (o_spi_sdi),
    .i_spi_sdo    (i_spi_sdo),
    .o_dbg_state  (o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [23:0] data;
    logic [5:0]  base;
    logic        poke;
    int          exp_done;
    int          exp_rises;
    int          exp_cs;
  } vec_t;

  vec_t        vecs[6];
  logic [47:0] exp_q[$];
  logic [23:0] wr_q[$];
  logic [47:0] adc_model;
  logic [5:0]  pat[8];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc, rises, falls, cs_low;
  logic        sclk_prev, sdi_prev;
  logic [23:0] sdi_word;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: sample at the falling clk edge, track SCLK edges, then drive SDO
  // the way the ADC does (MSB valid from CS, next bit after each SCLK fall).
  task automatic step();
    @(negedge clk);
    cyc++;
    if (!o_spi_cs_n) cs_low++;
    if (o_spi_sclk && !sclk_prev) rises++;
    if (!o_spi_sclk && sclk_prev) begin
      falls++;
      sdi_word = {sdi_word[22:0], sdi_prev};
    end
    sclk_prev = o_spi_sclk;
    sdi_prev  = o_spi_sdi;
    for (int k = 0; k < 8; k++) begin
      i_spi_sdo[k] = (falls < 6) ? pat[k][3'(5 - falls)] : 1'b0;
    end
  endtask

  task automatic new_frame_stats();
    rises = 0; falls = 0; cs_low = 0; cyc = 0;
    sclk_prev = 1'b0; sdi_prev = 1'b0; sdi_word = '0;
  endtask

  task automatic run_frame(input vec_t v);
    logic [47:0] e;
    logic [47:0] got_exp;
    logic [23:0] got_wr;
    int          done_cyc;
    logic        busy_ok;
    logic        cs_at_done;
    for (int k = 0; k < 8; k++) pat[k] = v.base ^ 6'(k);
    if (v.wr) begin
      wr_q.push_back(v.data);
      e = adc_model;
    end else begin
      for (int k = 0; k < 8; k++) e[k*6 +: 6] = pat[k];
      adc_model = e;
    end
    exp_q.push_back(e);
    new_frame_stats();
    for (int k = 0; k < 8; k++) i_spi_sdo[k] = pat[k][5];
    i_wr_start = v.wr;
    i_rd_start = v.rd;
    i_wr_data  = v.data;
    done_cyc   = -1;
    busy_ok    = 1'b1;
    cs_at_done = 1'b0;
    for (int n = 0; n < 300 && done_cyc < 0; n++) begin
      step();
      i_wr_start = 1'b0;
      i_rd_start = v.poke && (cyc == 3 || cyc == 10);
      if (!o_busy) busy_ok = 1'b0;
      if (o_spi_done) begin
        done_cyc   = cyc;
        cs_at_done = o_spi_cs_n;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_done", 64'd1, 64'd0);
        end else begin
          got_exp = exp_q.pop_front();
          check("adc_data", adc_all, got_exp);
        end
        if (v.wr) begin
          got_wr = wr_q.pop_front();
          check("sdi_word", sdi_word, got_wr);
        end
      end
    end
    i_rd_start = 1'b0;
    check("done_cycle", done_cyc, v.exp_done);
    check("sclk_rises", rises, v.exp_rises);
    check("cs_low_cycles", cs_low, v.exp_cs);
    check("busy_through_done", busy_ok, 1'b1);
    check("cs_high_at_done", cs_at_done, 1'b1);
  endtask

  task automatic idle_check(input int n);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      if (o_spi_done || !o_spi_cs_n || o_busy || o_spi_sclk) ok = 1'b0;
    end
    check("idle_quiet", ok, 1'b1);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{1'b0, 1'b1, 24'h00_0000, 6'h2A, 1'b0, 17,  6,  16};
    vecs[1] = '{1'b1, 1'b0, INIT_CFG_IN, 6'h00, 1'b0, 101, 24, 100};
    vecs[2] = '{1'b0, 1'b1, 24'h00_0000, 6'h15, 1'b1, 17,  6,  16};
    vecs[3] = '{1'b1, 1'b1, INIT_4LANE,  6'h00, 1'b0, 101, 24, 100};
    vecs[4] = '{1'b1, 1'b0, INIT_CFG_OUT, 6'h00, 1'b0, 101, 24, 100};
    vecs[5] = '{1'b0, 1'b1, 24'h00_0000, 6'h3F, 1'b0, 17,  6,  16};

    i_rst = 1'b1; i_rd_start = 1'b0; i_wr_start = 1'b0;
    i_wr_data = '0; i_spi_sdo = '0; adc_model = '0;
    for (int k = 0; k < 8; k++) pat[k] = '0;
    new_frame_stats();
    repeat (3) step();
    check("rst_cs_n", o_spi_cs_n, 1'b1);
    check("rst_sclk", o_spi_sclk, 1'b0);
    check("rst_sdi", o_spi_sdi, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_spi_done, 1'b0);
    check("rst_adc", adc_all, 48'h0);
    check("rst_state", o_dbg_state, ST_IDLE);
    i_rst = 1'b0;
    idle_check(2);

    foreach (vecs[i]) begin
      run_frame(vecs[i]);
      idle_check(4);
    end

    // Reset in the middle of a read, while SCLK is high.
    for (int k = 0; k < 8; k++) pat[k] = 6'h2A ^ 6'(k);
    new_frame_stats();
    i_rd_start = 1'b1;
    while (cyc < 8) begin
      step();
      i_rd_start = 1'b0;
    end
    check("sclk_high_before_rst", o_spi_sclk, 1'b1);
    i_rst = 1'b1;
    #1;
    check("midrst_cs_n", o_spi_cs_n, 1'b1);
    check("midrst_sclk", o_spi_sclk, 1'b0);
    check("midrst_busy", o_busy, 1'b0);
    check("midrst_done", o_spi_done, 1'b0);
    check("midrst_adc", adc_all, 48'h0);
    adc_model = '0;
    repeat (2) step();
    i_rst = 1'b0;
    idle_check(6);
    check("post_rst_adc", adc_all, 48'h0);
    v = '{1'b0, 1'b1, 24'h0, 6'h0C, 1'b0, 17, 6, 16};
    run_frame(v);

    // Back-to-back reads, each started in the cycle after the previous done.
    for (int r = 0; r < 3; r++) begin
      step();
      check("cs_high_between", o_spi_cs_n, 1'b1);
      v = '{1'b0, 1'b1, 24'h0, 6'($urandom_range(0, 63)), 1'b0, 17, 6, 16};
      run_frame(v);
    end
    idle_check(3);
    check("sb_drained", exp_q.size() + wr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
